// File: rtl/fa_cache_tag_controller.sv
// fa_cache_tag_controller
// Fully-associative tag store plus miss sequencer that sits in front of a
// FIFO replacement-policy controller. A lookup compares the registered tag
// against every valid entry. On a hit, the matching slot is returned. On a
// miss, the block pulses the policy controller and takes the victim slot.
// It then requests a fill, installs the tag once the fill is acknowledged,
// and responds.
//
// Optional feature macro: FA_CACHE_TAG_STATS_EN
//   When defined, adds hit_count_o / miss_count_o. These are saturating
//   response counters, cleared by reset and by an honoured flush.
//
// Ports
//   clock_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o     lookup request handshake, req_tag_i payload
//   flush_i                     invalidate all entries (IDLE only)
//   resp_valid_o                one-cycle response pulse; resp_hit_o/resp_addr_o
//                               hold their value until the next response
//   miss_o                      one-cycle pulse to policy controller miss_i
//   repl_done_i/repl_addr_i     policy controller done_o/addr_o
//   fill_req_o/fill_ack_i       fill handshake; fill_tag_o/fill_addr_o stay stable
//   state_dbg_o                 current FSM state encoding
//   hit_count_o/miss_count_o    (FA_CACHE_TAG_STATS_EN only) response counters
//
// Handshakes: a request transfers on a clock edge where req_valid_i and
// req_ready_o are both 1. req_ready_o is 1 only in IDLE with flush_i low.
// A fill completes on a clock edge where fill_req_o and fill_ack_i are both
// 1. fill_ack_i is ignored at any other time.
module fa_cache_tag_controller #(
  parameter int CACHE_BLOCK_CAPACITY = 16,
  parameter int BW_TAG               = 24,
  parameter int BW_CACHE_CAPACITY    = $clog2(CACHE_BLOCK_CAPACITY)
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [BW_TAG-1:0]            req_tag_i,
  input  logic                         flush_i,
  output logic                         resp_valid_o,
  output logic                         resp_hit_o,
  output logic [BW_CACHE_CAPACITY-1:0] resp_addr_o,
  output logic                         miss_o,
  input  logic                         repl_done_i,
  input  logic [BW_CACHE_CAPACITY-1:0] repl_addr_i,
  output logic                         fill_req_o,
  output logic [BW_TAG-1:0]            fill_tag_o,
  output logic [BW_CACHE_CAPACITY-1:0] fill_addr_o,
  input  logic                         fill_ack_i,
`ifdef FA_CACHE_TAG_STATS_EN
  output logic [31:0]                  hit_count_o,
  output logic [31:0]                  miss_count_o,
`endif
  output logic [2:0]                   state_dbg_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_MISS      = 3'd2,
    ST_WAIT_REPL = 3'd3,
    ST_FILL      = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [BW_TAG-1:0]               tag_mem [CACHE_BLOCK_CAPACITY];
  logic [CACHE_BLOCK_CAPACITY-1:0] valid_q;
  logic [BW_TAG-1:0]               tag_q;
  logic [BW_CACHE_CAPACITY-1:0]    slot_q;
  logic                            resp_hit_q;
  logic [BW_CACHE_CAPACITY-1:0]    resp_addr_q;

  logic                            hit;
  logic [BW_CACHE_CAPACITY-1:0]    hit_idx;

  // Scan from high to low so that the lowest matching index is written last.
  // This only matters if duplicate tags ever exist, which should not happen.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = CACHE_BLOCK_CAPACITY - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_mem[i] == tag_q)) begin
        hit     = 1'b1;
        hit_idx = i[BW_CACHE_CAPACITY-1:0];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    miss_o       = 1'b0;
    fill_req_o   = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Flush takes priority, so no request is accepted in a flush cycle.
        req_ready_o = !flush_i;
        if (!flush_i && req_valid_i) state_d = ST_COMPARE;
      end
      ST_COMPARE:   state_d = hit ? ST_RESP : ST_MISS;
      ST_MISS: begin
        miss_o  = 1'b1;
        state_d = ST_WAIT_REPL;
      end
      // repl_done_i is a level that stays high after the first miss.
      // It is therefore only looked at in this state.
      ST_WAIT_REPL: if (repl_done_i) state_d = ST_FILL;
      ST_FILL: begin
        fill_req_o = 1'b1;
        if (fill_ack_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q     <= '0;
      tag_q       <= '0;
      slot_q      <= '0;
      resp_hit_q  <= 1'b0;
      resp_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_i)          valid_q <= '0;
          else if (req_valid_i) tag_q   <= req_tag_i;
        end
        ST_COMPARE: begin
          if (hit) begin
            resp_hit_q  <= 1'b1;
            resp_addr_q <= hit_idx;
          end
        end
        ST_WAIT_REPL: if (repl_done_i) slot_q <= repl_addr_i;
        ST_FILL: begin
          if (fill_ack_i) begin
            valid_q[slot_q] <= 1'b1;
            resp_hit_q      <= 1'b0;
            resp_addr_q     <= slot_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag storage needs no reset: an entry is never read while its valid bit is clear.
  always_ff @(posedge clock_i) begin
    if (!reset_i && (state_q == ST_FILL) && fill_ack_i) tag_mem[slot_q] <= tag_q;
  end

  assign resp_hit_o  = resp_hit_q;
  assign resp_addr_o = resp_addr_q;
  assign fill_tag_o  = tag_q;
  assign fill_addr_o = slot_q;
  assign state_dbg_o = state_q;

`ifdef FA_CACHE_TAG_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || ((state_q == ST_IDLE) && flush_i)) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_valid_o) begin
      if (resp_hit_q && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!resp_hit_q && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fa_cache_tag_controller.sv
// Testbench for fa_cache_tag_controller.
// A reference model (tag array, valid array, FIFO victim pointer) predicts each
// response when the request is issued. A negedge monitor pops and compares every
// response. Small behavioural stubs stand in for the policy controller and the
// memory-side fill responder.
module tb_fa_cache_tag_controller;

  localparam int N  = 16;
  localparam int TW = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [TW-1:0] req_tag_i = '0;
  logic          flush_i = 1'b0;
  logic          resp_valid_o, resp_hit_o;
  logic [AW-1:0] resp_addr_o;
  logic          miss_o;
  logic          repl_done_i = 1'b0;
  logic [AW-1:0] repl_addr_i = '0;
  logic          fill_req_o;
  logic [TW-1:0] fill_tag_o;
  logic [AW-1:0] fill_addr_o;
  logic          fill_ack_i = 1'b0;
  logic [2:0]    state_dbg;
`ifdef FA_CACHE_TAG_STATS_EN
  logic [31:0]   hit_count_o, miss_count_o;
`endif

  fa_cache_tag_controller #(.CACHE_BLOCK_CAPACITY(N), .BW_TAG(TW)) dut (
    .clock_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_tag_i(req_tag_i),
    .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_addr_o(resp_addr_o),
    .miss_o(miss_o), .repl_done_i(repl_done_i), .repl_addr_i(repl_addr_i),
    .fill_req_o(fill_req_o), .fill_tag_o(fill_tag_o), .fill_addr_o(fill_addr_o),
    .fill_ack_i(fill_ack_i),
`ifdef FA_CACHE_TAG_STATS_EN
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
`endif
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [TW-1:0] m_tag [N];
  logic          m_valid [N];
  logic [AW-1:0] m_ptr = '0;
  int            m_hits = 0, m_misses = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr = '0;
  endtask

  task automatic model_lookup(input logic [TW-1:0] t, output logic h, output logic [AW-1:0] a);
    h = 1'b0;
    a = '0;
    for (int i = 0; i < N; i++) begin
      if (!h && m_valid[i] && m_tag[i] == t) begin
        h = 1'b1;
        a = i[AW-1:0];
      end
    end
    if (!h) begin
      a = m_ptr;
      m_tag[m_ptr]   = t;
      m_valid[m_ptr] = 1'b1;
      m_ptr          = m_ptr + 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW:0]   exp_q [$];
  int            iss_q [$];
  logic [TW-1:0] cur_fill_tag = '0;
  logic [AW-1:0] cur_fill_addr = '0;
  int            fill_delay = 0;

  // ---------------- policy controller stub (FIFO victim, level done) ----------------
  logic [AW-1:0] pol_ptr = '0;
  always @(negedge clk) begin
    if (reset_i) begin
      pol_ptr = '0; repl_done_i = 1'b0; repl_addr_i = '0;
    end else if (miss_o) begin
      repl_addr_i = pol_ptr;
      pol_ptr     = pol_ptr + 1'b1;
      repl_done_i = 1'b1;
    end
  end

  // ---------------- fill responder (spurious acks outside FILL) ----------------
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (reset_i) begin
      fill_ack_i = 1'b0; wait_cnt = 0;
    end else if (fill_req_o) begin
      if (wait_cnt >= fill_delay) fill_ack_i = 1'b1;
      else begin fill_ack_i = 1'b0; wait_cnt++; end
    end else begin
      fill_ack_i = ($urandom_range(0, 3) == 0);
      wait_cnt   = 0;
    end
  end

  // ---------------- monitor ----------------
  int   miss_seen = 0;
  logic prev_miss = 1'b0;
  always @(negedge clk) begin
    logic [AW:0] e;
    int          t0;
    if (reset_i) begin
      miss_seen = 0; prev_miss = 1'b0;
    end else begin
      if (miss_o) begin
        if (prev_miss) check("miss_pulse_width", 32'd2, 32'd1);
        miss_seen++;
      end
      prev_miss = miss_o;
      if (fill_req_o) begin
        check("fill_tag", 32'(fill_tag_o), 32'(cur_fill_tag));
        check("fill_addr", 32'(fill_addr_o), 32'(cur_fill_addr));
      end
      if (resp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          t0 = iss_q.pop_front();
          check("resp_hit", 32'(resp_hit_o), 32'(e[AW]));
          check("resp_addr", 32'(resp_addr_o), 32'(e[AW-1:0]));
          check("miss_pulses", miss_seen, e[AW] ? 0 : 1);
          if (e[AW]) check("hit_latency", cyc - t0, 2);
          if (e[AW]) m_hits++; else m_misses++;
        end
        miss_seen = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 300) begin @(negedge clk); n++; end
    ok = (n < 300);
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic [TW-1:0] t, input int delay);
    bit            ok;
    logic          h;
    logic [AW-1:0] a;
    wait_ready(ok);
    if (!ok) return;
    model_lookup(t, h, a);
    exp_q.push_back({h, a});
    iss_q.push_back(cyc);
    if (!h) begin cur_fill_tag = t; cur_fill_addr = a; end
    fill_delay  = delay;
    req_valid_i = 1'b1;
    req_tag_i   = t;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_tag_i   = TW'($urandom);
  endtask

  task automatic do_flush(input logic [TW-1:0] t);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    req_tag_i   = t;
    #1;
    check("flush_ready_low", 32'(req_ready_o), 32'd0);
    model_reset_valid_only();
    m_hits = 0; m_misses = 0;
    @(negedge clk);
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
  endtask

  task automatic model_reset_valid_only();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    model_reset();

    // Reset with a request pending: it must be ignored.
    req_valid_i = 1'b1;
    req_tag_i   = 24'h123;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_miss", 32'(miss_o), 32'd0);
    check("rst_fill_req", 32'(fill_req_o), 32'd0);
    check("rst_resp_addr", 32'(resp_addr_o), 32'd0);
    req_valid_i = 1'b0;
    reset_i     = 1'b0;

    // Cold miss on 0xABC filled into slot 0, then a 2-cycle hit.
    do_req(24'hABC, 3);
    do_req(24'hABC, 0);
    drain();

    // Reset while a fill is outstanding.
    do_req(24'hDEAD, 1000);
    n = 0;
    while (!fill_req_o && n < 50) begin @(negedge clk); n++; end
    check("fill_req_seen", 32'(fill_req_o), 32'd1);
    reset_i = 1'b1;
    exp_q.delete();
    iss_q.delete();
    model_reset();
    m_hits = 0; m_misses = 0;
    @(negedge clk);
    check("midrst_fill_req", 32'(fill_req_o), 32'd0);
    check("midrst_ready", 32'(req_ready_o), 32'd1);
    check("midrst_resp_valid", 32'(resp_valid_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    do_req(24'hABC, 1);  // installed before the reset, so this must miss

    // 17 distinct tags: FIFO wraps back to slot 0, old slot-0 tag then misses.
    for (int i = 0; i < 17; i++) do_req(24'h100 + 24'(i), $urandom_range(0, 3));
    do_req(24'hABC, 0);
    do_req(24'h110, 0);
    drain();

    // Flush competing with a request; the cached tag must miss afterwards.
    do_flush(24'h110);
    do_req(24'h110, 2);
    drain();

    // Randomised traffic over a pool larger than the capacity.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) do_flush(24'h5000 + 24'($urandom_range(0, 23)));
      else do_req(24'h5000 + 24'($urandom_range(0, 23)), $urandom_range(0, 3));
    end
    drain();

`ifdef FA_CACHE_TAG_STATS_EN
    check("stats_hits_model", hit_count_o, m_hits);
    check("stats_miss_model", miss_count_o, m_misses);
    do_flush(24'h0);
    do_req(24'h7001, 1);
    do_req(24'h7002, 0);
    for (int i = 0; i < 3; i++) do_req(24'h7001 + 24'(i & 1), 0);
    drain();
    check("stats_hits", hit_count_o, 32'd3);
    check("stats_misses", miss_count_o, 32'd2);
    do_flush(24'h0);
    @(negedge clk);
    check("stats_hits_flush", hit_count_o, 32'd0);
    check("stats_miss_flush", miss_count_o, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
